// File: rtl/lsu_mem_master.sv
// Load/store unit: turns RISC-V byte-addressed loads/stores into word-aligned,
// byte-masked memory cycles, splitting word-crossing accesses into two cycles.
module lsu_mem_master #(
    parameter int SPLIT_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_cross;
    logic        r_err;
    logic [31:0] r_lo;
    logic [31:0] r_hi;
    logic [31:0] r_last_addr;

    logic [3:0]  w_bytes;
    logic        w_cross;
    logic        w_illegal;
    logic        w_accept;
    logic [7:0]  w_lanes;
    logic [7:0]  w_mask;
    logic [4:0]  w_sh;
    logic [5:0]  w_sh_hi;
    logic [31:0] w_raw;
    logic [31:0] w_ext;

    // Decode of the incoming request, used only on the accept cycle.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   w_bytes = 4'd1;
            2'b01:   w_bytes = 4'd2;
            default: w_bytes = 4'd4;
        endcase
        w_cross   = ({2'b00, req_addr[1:0]} + w_bytes) > 4'd4;
        w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                  || (req_we && req_funct3[2])
                  || (w_cross && (SPLIT_EN == 0));
    end

    // Byte-lane mask and shift amounts for the registered request.
    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_lanes = 8'h01;
            2'b01:   w_lanes = 8'h03;
            default: w_lanes = 8'h0F;
        endcase
        w_mask  = w_lanes << r_addr[1:0];
        w_sh    = {r_addr[1:0], 3'b000};
        w_sh_hi = 6'd32 - {1'b0, w_sh};
    end

    always_comb begin
        w_raw = r_lo | (r_cross ? r_hi : 32'h0);
        case (r_funct3)
            3'b000:  w_ext = {{24{w_raw[7]}}, w_raw[7:0]};
            3'b100:  w_ext = {24'h0, w_raw[7:0]};
            3'b001:  w_ext = {{16{w_raw[15]}}, w_raw[15:0]};
            3'b101:  w_ext = {16'h0, w_raw[15:0]};
            default: w_ext = w_raw;
        endcase
    end

    // NOTE: every output gets a default before the case, so no state leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        mem_we       = 4'h0;
        mem_wd       = 32'h0;
        mem_addr     = r_last_addr;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = w_illegal ? RESP : ACC1;
                end
            end
            ACC1: begin
                mem_addr     = {r_addr[31:2], 2'b00};
                mem_we       = r_we ? w_mask[3:0] : 4'h0;
                mem_wd       = r_wdata << w_sh;
                w_state_next = r_cross ? ACC2 : RESP;
            end
            ACC2: begin
                mem_addr     = {r_addr[31:2] + 30'd1, 2'b00};
                mem_we       = r_we ? w_mask[7:4] : 4'h0;
                mem_wd       = r_wdata >> w_sh_hi;
                w_state_next = RESP;
            end
            RESP: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign req_ready  = (r_state == IDLE) && rst;
    assign resp_valid = (r_state == RESP);
    assign resp_err   = (r_state == RESP) && r_err;
    assign resp_rdata = ((r_state == RESP) && !r_we && !r_err) ? w_ext : 32'h0;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of its inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_cross     <= 1'b0;
            r_err       <= 1'b0;
            r_lo        <= 32'h0;
            r_hi        <= 32'h0;
            r_last_addr <= 32'h0;
        end else begin
            r_state     <= w_state_next;
            r_last_addr <= mem_addr;
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_cross  <= w_cross;
                r_err    <= w_illegal;
                r_lo     <= 32'h0;
                r_hi     <= 32'h0;
            end
            if (r_state == ACC1) r_lo <= mem_rd >> w_sh;
            if (r_state == ACC2) r_hi <= mem_rd << w_sh_hi;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: a word memory model serves the split
// instance; a second instance with splitting disabled checks the error path.
module tb_lsu_mem_master;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wd;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;
    logic [3:0]  mem_we;

    logic        req_valid2 = 1'b0, req_we2 = 1'b0;
    logic [2:0]  req_funct32 = 3'b0;
    logic [31:0] req_addr2 = 32'h0, req_wdata2 = 32'h0;
    logic        req_ready2, resp_valid2, resp_err2;
    logic [31:0] resp_rdata2, mem_addr2, mem_wd2, mem_rd2;
    logic [3:0]  mem_we2;

    logic [31:0] mem [0:255];
    resp_t       q_resp[$];
    resp_t       q_resp2[$];
    acc_t        q_acc[$];

    lsu_mem_master #(.SPLIT_EN(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    lsu_mem_master #(.SPLIT_EN(0)) u_dut_nosplit (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
        .req_funct3(req_funct32), .req_addr(req_addr2), .req_wdata(req_wdata2),
        .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .resp_err(resp_err2),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wd(mem_wd2), .mem_rd(mem_rd2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Word memory with asynchronous read; 256 words cover every address used.
    assign mem_rd  = mem[mem_addr[9:2]];
    assign mem_rd2 = 32'h8001_1234;
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_we[i]) mem[mem_addr[9:2]][8*i +: 8] = mem_wd[8*i +: 8];
    end

    task automatic note_fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) note_fail(name, act, exp);
    endtask

    function automatic void push_resp(input bit d2, input int c, input logic err, input logic [31:0] rd);
        resp_t e;
        e.cyc = c; e.err = err; e.rdata = rd;
        if (d2) q_resp2.push_back(e);
        else    q_resp.push_back(e);
    endfunction

    function automatic void push_acc(input int c, input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        acc_t e;
        e.cyc = c; e.addr = a; e.we = we; e.wd = wd;
        q_acc.push_back(e);
    endfunction

    // Monitor: compare responses and memory cycles against the queues.
    always @(negedge clk) begin : mon_main
        resp_t e;
        acc_t  a;
        if (resp_valid) begin
            if (q_resp.size() == 0) begin
                checks++;
                note_fail("resp_unexpected", 32'd1, 32'd0);
            end else begin
                e = q_resp.pop_front();
                check("resp_cycle", cyc, e.cyc);
                check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                check("resp_rdata", resp_rdata, e.rdata);
            end
        end
        if (q_acc.size() != 0 && q_acc[0].cyc == cyc) begin
            a = q_acc.pop_front();
            check("mem_addr", mem_addr, a.addr);
            check("mem_we", {28'b0, mem_we}, {28'b0, a.we});
            check("mem_wd", mem_wd, a.wd);
        end else if (mem_we != 4'h0) begin
            checks++;
            note_fail("mem_we_unexpected", {28'b0, mem_we}, 32'd0);
        end
    end

    always @(negedge clk) begin : mon_nosplit
        resp_t e;
        if (resp_valid2) begin
            if (q_resp2.size() == 0) begin
                checks++;
                note_fail("resp2_unexpected", 32'd1, 32'd0);
            end else begin
                e = q_resp2.pop_front();
                check("resp2_cycle", cyc, e.cyc);
                check("resp2_err", {31'b0, resp_err2}, {31'b0, e.err});
                check("resp2_rdata", resp_rdata2, e.rdata);
            end
        end
        if (mem_we2 != 4'h0) begin
            checks++;
            note_fail("mem_we2_unexpected", {28'b0, mem_we2}, 32'd0);
        end
    end

    // Waits for ready, presents one request for exactly its accept cycle and
    // returns the accept cycle number (-1 if ready never came).
    task automatic issue(input bit d2, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, output int t);
        bit rdy = 1'b0;
        t = -1;
        for (int n = 0; n < 20 && !rdy; n++) begin
            @(posedge clk);
            #1;
            rdy = d2 ? req_ready2 : req_ready;
        end
        if (!rdy) begin
            checks++;
            note_fail("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        if (d2) begin
            req_valid2 = 1'b1; req_we2 = we; req_funct32 = f3; req_addr2 = addr; req_wdata2 = wd;
        end else begin
            req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        end
        t = cyc;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_valid2 = 1'b0;
    endtask

    initial begin
        int t;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'hFF] = 32'hAA00_0000;   // word 0xFFFFFFFC
        mem[8'h00] = 32'h00CC_BBAA;   // word 0x00000000

        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_mem_we", {28'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_release_ready", {31'b0, req_ready}, 32'd1);

        // SW 0x100
        issue(0, 1, 3'b010, 32'h100, 32'h1122_3344, t);
        push_acc(t+1, 32'h100, 4'b1111, 32'h1122_3344);
        push_resp(0, t+2, 0, 32'h0);
        // SB 0x103, then LBU / LB of the same byte
        issue(0, 1, 3'b000, 32'h103, 32'h0000_00AB, t);
        push_acc(t+1, 32'h100, 4'b1000, 32'hAB00_0000);
        push_resp(0, t+2, 0, 32'h0);
        issue(0, 0, 3'b100, 32'h103, 32'h0, t);
        push_acc(t+1, 32'h100, 4'b0000, 32'h0);
        push_resp(0, t+2, 0, 32'h0000_00AB);
        issue(0, 0, 3'b000, 32'h103, 32'h0, t);
        push_acc(t+1, 32'h100, 4'b0000, 32'h0);
        push_resp(0, t+2, 0, 32'hFFFF_FFAB);
        // Word 0x100 = 0x80011234, then LH / LHU 0x102
        issue(0, 1, 3'b010, 32'h100, 32'h8001_1234, t);
        push_acc(t+1, 32'h100, 4'b1111, 32'h8001_1234);
        push_resp(0, t+2, 0, 32'h0);
        issue(0, 0, 3'b001, 32'h102, 32'h0, t);
        push_acc(t+1, 32'h100, 4'b0000, 32'h0);
        push_resp(0, t+2, 0, 32'hFFFF_8001);
        issue(0, 0, 3'b101, 32'h102, 32'h0, t);
        push_acc(t+1, 32'h100, 4'b0000, 32'h0);
        push_resp(0, t+2, 0, 32'h0000_8001);
        // Crossing SW 0x106 and LW back
        issue(0, 1, 3'b010, 32'h106, 32'hDEAD_BEEF, t);
        push_acc(t+1, 32'h104, 4'b1100, 32'hBEEF_0000);
        push_acc(t+2, 32'h108, 4'b0011, 32'h0000_DEAD);
        push_resp(0, t+3, 0, 32'h0);
        issue(0, 0, 3'b010, 32'h106, 32'h0, t);
        push_acc(t+1, 32'h104, 4'b0000, 32'h0);
        push_acc(t+2, 32'h108, 4'b0000, 32'h0);
        push_resp(0, t+3, 0, 32'hDEAD_BEEF);
        // Wrap-around loads: offset 1 takes bytes FFD..FFF,000; offset 3
        // takes FFF,000..002 = {mem0[23:0], memFFC[31:24]}.
        issue(0, 0, 3'b010, 32'hFFFF_FFFD, 32'h0, t);
        push_acc(t+1, 32'hFFFF_FFFC, 4'b0000, 32'h0);
        push_acc(t+2, 32'h0000_0000, 4'b0000, 32'h0);
        push_resp(0, t+3, 0, 32'hAAAA_0000);
        issue(0, 0, 3'b010, 32'hFFFF_FFFF, 32'h0, t);
        push_acc(t+1, 32'hFFFF_FFFC, 4'b0000, 32'h0);
        push_acc(t+2, 32'h0000_0000, 4'b0000, 32'h0);
        push_resp(0, t+3, 0, 32'hCCBB_AAAA);
        // Illegal funct3 and illegal store size: error at T+1, no memory cycle
        issue(0, 0, 3'b011, 32'h100, 32'h0, t);
        push_resp(0, t+1, 1, 32'h0);
        issue(0, 1, 3'b100, 32'h100, 32'hFFFF_FFFF, t);
        push_resp(0, t+1, 1, 32'h0);

        // Reset during the second half of a split store
        issue(0, 1, 3'b010, 32'h10A, 32'hCAFE_F00D, t);
        push_acc(t+1, 32'h108, 4'b1100, 32'hF00D_0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_mem_we", {28'b0, mem_we}, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_mem_wd", mem_wd, 32'd0);
        check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("abort_req_ready", {31'b0, req_ready}, 32'd0);
        check("abort_first_half_kept", mem[8'h42], 32'hF00D_DEAD);
        check("abort_second_half_absent", mem[8'h43], 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_ready_after", {31'b0, req_ready}, 32'd1);
        issue(0, 0, 3'b010, 32'h108, 32'h0, t);
        push_acc(t+1, 32'h108, 4'b0000, 32'h0);
        push_resp(0, t+2, 0, 32'hF00D_DEAD);
        issue(0, 0, 3'b010, 32'h10C, 32'h0, t);
        push_acc(t+1, 32'h10C, 4'b0000, 32'h0);
        push_resp(0, t+2, 0, 32'h0);

        // No-split instance: aligned half works, crossing accesses error out
        issue(1, 0, 3'b001, 32'h102, 32'h0, t);
        push_resp(1, t+2, 0, 32'hFFFF_8001);
        issue(1, 0, 3'b001, 32'h103, 32'h0, t);
        push_resp(1, t+1, 1, 32'h0);
        issue(1, 0, 3'b010, 32'h101, 32'h0, t);
        push_resp(1, t+1, 1, 32'h0);

        for (int n = 0; n < 20 && (q_resp.size() + q_resp2.size() + q_acc.size()) != 0; n++)
            @(posedge clk);
        repeat (2) @(posedge clk);
        check("resp_queue_drained", q_resp.size(), 32'd0);
        check("resp2_queue_drained", q_resp2.size(), 32'd0);
        check("acc_queue_drained", q_acc.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
